// File: rtl/zynq_axi3_burst_master.sv
// zynq_axi3_burst_master
//   Single-outstanding AXI3 burst initiator. One command (direction, byte
//   address, beats-1) becomes one INCR burst on m_axi_*. Write beats stream in
//   on wdata_*; read beats stream out on rdata_*. A one-cycle done pulse with
//   an error flag closes every transaction.
//
// Ports
//   clk_i, reset_i           clock, asynchronous active-high reset
//   cmd_*                    command request (write, addr, len = beats-1)
//   wdata_*                  write beat stream into the burst
//   rdata_*                  read beat stream out of the burst
//   done_v_o, done_err_o     completion pulse and error status
//   dbg_state_o              current FSM state (IDLE=0 AW=1 W=2 B=3 AR=4 R=5 DONE=6)
//   m_axi_aw*/w*/b*/ar*/r*   AXI3 master channels
//
// Handshake rule for every valid/ready pair in this block: a transfer happens
// on a rising clock edge where valid and ready are both high; once valid is
// raised, the payload stays stable until that transfer.
module zynq_axi3_burst_master #(
   parameter int addr_width_p = 32,
   parameter int data_width_p = 64,
   parameter int id_width_p   = 6,
   parameter int len_width_p  = 4,
   parameter int axi_id_p     = 0
) (
   input  logic                      clk_i,
   input  logic                      reset_i,

   input  logic                      cmd_v_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [addr_width_p-1:0]   cmd_addr_i,
   input  logic [len_width_p-1:0]    cmd_len_i,

   input  logic [data_width_p-1:0]   wdata_i,
   input  logic                      wdata_v_i,
   output logic                      wdata_ready_o,

   output logic [data_width_p-1:0]   rdata_o,
   output logic                      rdata_v_o,
   output logic                      rdata_last_o,
   input  logic                      rdata_ready_i,

   output logic                      done_v_o,
   output logic                      done_err_o,
   output logic [2:0]                dbg_state_o,

   output logic [addr_width_p-1:0]   m_axi_awaddr,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [id_width_p-1:0]     m_axi_awid,
   output logic [len_width_p-1:0]    m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic [1:0]                m_axi_awlock,
   output logic [3:0]                m_axi_awcache,
   output logic [2:0]                m_axi_awprot,
   output logic [3:0]                m_axi_awqos,

   output logic [data_width_p-1:0]   m_axi_wdata,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   output logic [id_width_p-1:0]     m_axi_wid,
   output logic                      m_axi_wlast,
   output logic [data_width_p/8-1:0] m_axi_wstrb,

   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   input  logic [id_width_p-1:0]     m_axi_bid,
   input  logic [1:0]                m_axi_bresp,

   output logic [addr_width_p-1:0]   m_axi_araddr,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   output logic [id_width_p-1:0]     m_axi_arid,
   output logic [len_width_p-1:0]    m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic [1:0]                m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,

   input  logic [data_width_p-1:0]   m_axi_rdata,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   input  logic [id_width_p-1:0]     m_axi_rid,
   input  logic                      m_axi_rlast,
   input  logic [1:0]                m_axi_rresp
);

   localparam int STRB_W_LP = data_width_p / 8;
   localparam int SIZE_LP   = $clog2(STRB_W_LP);
   localparam logic [id_width_p-1:0] ID_LP = id_width_p'(axi_id_p);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_AW   = 3'd1,
      ST_W    = 3'd2,
      ST_B    = 3'd3,
      ST_AR   = 3'd4,
      ST_R    = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [addr_width_p-1:0]   r_addr;
   logic [len_width_p-1:0]    r_len;
   logic [len_width_p-1:0]    r_cnt;
   logic                      r_err;

   logic                      w_cmd_hs;
   logic                      w_w_hs;
   logic                      w_r_hs;
   logic                      w_last_beat;
   logic [addr_width_p-1:0]   w_cmd_addr_aligned;
   logic [23:0]               w_burst_end;
   logic                      w_cross_4k;
   logic                      w_unused;

   // Byte lanes below the bus width are dropped: every beat is a full beat.
   assign w_cmd_addr_aligned = cmd_addr_i & ~addr_width_p'(STRB_W_LP - 1);

   // One past the last byte of the burst, relative to the 4 KB page start.
   assign w_burst_end = 24'(w_cmd_addr_aligned[11:0])
                      + ((24'(cmd_len_i) + 24'd1) << SIZE_LP);
   assign w_cross_4k  = (w_burst_end > 24'd4096);

   // cmd_ready_o is also masked by reset so no ready is seen while reset is held.
   assign cmd_ready_o = (r_state == ST_IDLE) & ~reset_i;
   assign w_cmd_hs    = cmd_v_i & cmd_ready_o;
   assign w_last_beat = (r_cnt == r_len);
   assign w_w_hs      = (r_state == ST_W) & wdata_v_i & m_axi_wready;
   assign w_r_hs      = (r_state == ST_R) & m_axi_rvalid & rdata_ready_i;

   // Write-address channel
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awvalid = (r_state == ST_AW);
   assign m_axi_awid    = ID_LP;
   assign m_axi_awlen   = r_len;
   assign m_axi_awsize  = 3'(SIZE_LP);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 2'b00;
   assign m_axi_awcache = 4'b0011;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awqos   = 4'b0000;

   // Write-data channel: the beat stream is passed straight through while in W.
   assign m_axi_wdata   = wdata_i;
   assign m_axi_wvalid  = (r_state == ST_W) & wdata_v_i;
   assign wdata_ready_o = (r_state == ST_W) & m_axi_wready;
   assign m_axi_wid     = ID_LP;
   assign m_axi_wlast   = (r_state == ST_W) & w_last_beat;
   assign m_axi_wstrb   = '1;

   // Write-response channel
   assign m_axi_bready  = (r_state == ST_B);

   // Read-address channel
   assign m_axi_araddr  = r_addr;
   assign m_axi_arvalid = (r_state == ST_AR);
   assign m_axi_arid    = ID_LP;
   assign m_axi_arlen   = r_len;
   assign m_axi_arsize  = 3'(SIZE_LP);
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 2'b00;
   assign m_axi_arcache = 4'b0011;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arqos   = 4'b0000;

   // Read-data channel: rdata_last_o follows our own beat count, not rlast.
   assign rdata_o       = m_axi_rdata;
   assign rdata_v_o     = (r_state == ST_R) & m_axi_rvalid;
   assign m_axi_rready  = (r_state == ST_R) & rdata_ready_i;
   assign rdata_last_o  = (r_state == ST_R) & w_last_beat;

   assign done_v_o      = (r_state == ST_DONE);
   assign done_err_o    = (r_state == ST_DONE) & r_err;
   assign dbg_state_o   = r_state;

   // IDs and the low response bit carry no information for a single-ID master.
   assign w_unused = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_cmd_hs)                   w_state_nxt = cmd_write_i ? ST_AW : ST_AR;
         ST_AW:   if (m_axi_awready)              w_state_nxt = ST_W;
         ST_W:    if (w_w_hs && w_last_beat)      w_state_nxt = ST_B;
         ST_B:    if (m_axi_bvalid)               w_state_nxt = ST_DONE;
         ST_AR:   if (m_axi_arready)              w_state_nxt = ST_R;
         // The burst ends on our count; a misplaced rlast only raises the error.
         ST_R:    if (w_r_hs && w_last_beat)      w_state_nxt = ST_DONE;
         ST_DONE:                                 w_state_nxt = ST_IDLE;
         default:                                 w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_addr <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_cmd_hs) begin
            r_addr <= w_cmd_addr_aligned;
            r_len  <= cmd_len_i;
            r_cnt  <= '0;
            r_err  <= 1'b0;
         end
         if (w_w_hs) r_cnt <= r_cnt + len_width_p'(1);
         if ((r_state == ST_B) && m_axi_bvalid) r_err <= r_err | m_axi_bresp[1];
         if (w_r_hs) begin
            r_cnt <= r_cnt + len_width_p'(1);
            r_err <= r_err | m_axi_rresp[1] | (m_axi_rlast != w_last_beat);
         end
      end
   end

   // Bursts are never split, so a page-crossing command is a caller bug.
   a_no_4k_cross: assert property (@(posedge clk_i) disable iff (reset_i)
      w_cmd_hs |-> !w_cross_4k);

endmodule
